// File: rtl/ipv4_tx_arb.sv
// rtl/ipv4_tx_arb.sv - packet-level round-robin arbiter in front of the IPv4 TX datapath
//
// Grants one requester at a time for a whole packet and muxes its stream onto
// the IPv4 TX input with zero latency. It also supplies the protocol number of
// the granted requester. A grant that never sees a start beat is revoked after
// TIMEOUT cycles.
//
// Ports:
//   clk, nreset                      clock, synchronous active-low reset
//   req_i[N]                         per-requester packet request (level)
//   grant_o[N]                       registered one-hot grant
//   valid_i/start_i/last_i/cancel_i  per-requester stream controls
//   data_i[N*DATA_W], len_i[N*LEN_W] per-requester data and byte count
//   valid_o/start_o/last_o/cancel_o  muxed stream controls to IPv4 TX
//   data_o, len_o                    muxed data and byte count to IPv4 TX
//   prot_o                           protocol of the current or last grant
//   to_err_o                         one-cycle pulse when a grant times out
module ipv4_tx_arb #(
    parameter int N = 2,
    parameter int DATA_W = 16,
    localparam int LEN_W = $clog2((DATA_W / 8) + 1),
    localparam int PROT_W = 8,
    parameter logic [N*PROT_W-1:0] PROTOCOLS = {8'd1, 8'd17},
    parameter int TIMEOUT = 64,
    localparam int TO_W = $clog2(TIMEOUT)
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [N-1:0]        req_i,
    output logic [N-1:0]        grant_o,
    input  logic [N-1:0]        valid_i,
    input  logic [N-1:0]        start_i,
    input  logic [N-1:0]        last_i,
    input  logic [N-1:0]        cancel_i,
    input  logic [N*DATA_W-1:0] data_i,
    input  logic [N*LEN_W-1:0]  len_i,
    output logic                valid_o,
    output logic                start_o,
    output logic                last_o,
    output logic                cancel_o,
    output logic [DATA_W-1:0]   data_o,
    output logic [LEN_W-1:0]    len_o,
    output logic [PROT_W-1:0]   prot_o,
    output logic                to_err_o
);

    localparam int G_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [G_W-1:0]    g_q, g_d;
    logic [G_W-1:0]    rr_q, rr_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [PROT_W-1:0] prot_q, prot_d;
    logic              to_err_q, to_err_d;

    logic              sel_found;
    logic [G_W-1:0]    sel_idx;
    int                idx;
    logic              fwd;
    logic              rel;

    logic              cur_valid, cur_start, cur_last, cur_cancel;
    logic [DATA_W-1:0] cur_data;
    logic [LEN_W-1:0]  cur_len;
    logic [G_W-1:0]    g_next;

    assign cur_valid  = valid_i[g_q];
    assign cur_start  = start_i[g_q];
    assign cur_last   = last_i[g_q];
    assign cur_cancel = cancel_i[g_q];
    assign cur_data   = data_i[g_q*DATA_W +: DATA_W];
    assign cur_len    = len_i[g_q*LEN_W +: LEN_W];
    assign g_next     = (g_q == G_W'(N - 1)) ? '0 : g_q + 1'b1;

    // Scan offsets from the far end down so the requester closest to rr_q
    // (offset 0) is the last writer and therefore wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % N;
            if (req_i[idx]) begin
                sel_found = 1'b1;
                sel_idx   = G_W'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        g_d      = g_q;
        rr_d     = rr_q;
        to_cnt_d = to_cnt_q;
        prot_d   = prot_q;
        to_err_d = 1'b0;
        fwd      = 1'b0;
        rel      = 1'b0;
        valid_o  = 1'b0;
        start_o  = 1'b0;
        last_o   = 1'b0;
        cancel_o = 1'b0;
        data_o   = '0;
        len_o    = '0;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d          = WAIT;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    g_d              = sel_idx;
                    prot_d           = PROTOCOLS[sel_idx*PROT_W +: PROT_W];
                    to_cnt_d         = '0;
                end
            end
            WAIT: begin
                // Only a start beat may open the packet; stray valid beats are dropped.
                fwd      = cur_valid & cur_start;
                valid_o  = fwd;
                start_o  = fwd;
                last_o   = fwd & cur_last;
                cancel_o = cur_cancel;
                data_o   = cur_data;
                len_o    = cur_len;
                if (cur_cancel) begin
                    rel = 1'b1;
                end else if (fwd) begin
                    if (cur_last) rel = 1'b1;
                    else          state_d = XFER;
                end else if (!req_i[g_q]) begin
                    rel = 1'b1;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    rel      = 1'b1;
                    to_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            XFER: begin
                // A repeated start mid-packet travels as ordinary data.
                valid_o  = cur_valid;
                last_o   = cur_valid & cur_last;
                cancel_o = cur_cancel;
                data_o   = cur_data;
                len_o    = cur_len;
                if (cur_cancel || (cur_valid && cur_last)) rel = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (rel) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = g_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            g_q      <= '0;
            rr_q     <= '0;
            to_cnt_q <= '0;
            prot_q   <= '0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            g_q      <= g_d;
            rr_q     <= rr_d;
            to_cnt_q <= to_cnt_d;
            prot_q   <= prot_d;
            to_err_q <= to_err_d;
        end
    end

    assign grant_o  = grant_q;
    assign prot_o   = prot_q;
    assign to_err_o = to_err_q;

endmodule

// File: tb/tb_ipv4_tx_arb.sv
// tb/tb_ipv4_tx_arb.sv - scoreboard testbench for ipv4_tx_arb
module tb_ipv4_tx_arb;

    logic        clk = 1'b0;
    logic        nreset;
    logic [1:0]  req_i, grant_o;
    logic [1:0]  valid_i, start_i, last_i, cancel_i;
    logic [31:0] data_i;
    logic [3:0]  len_i;
    logic        valid_o, start_o, last_o, cancel_o, to_err_o;
    logic [15:0] data_o;
    logic [1:0]  len_o;
    logic [7:0]  prot_o;

    always #5 clk = ~clk;

    ipv4_tx_arb #(.N(2), .DATA_W(16), .PROTOCOLS({8'd1, 8'd17}), .TIMEOUT(64)) dut (
        .clk(clk), .nreset(nreset), .req_i(req_i), .grant_o(grant_o),
        .valid_i(valid_i), .start_i(start_i), .last_i(last_i), .cancel_i(cancel_i),
        .data_i(data_i), .len_i(len_i),
        .valid_o(valid_o), .start_o(start_o), .last_o(last_o), .cancel_o(cancel_o),
        .data_o(data_o), .len_o(len_o), .prot_o(prot_o), .to_err_o(to_err_o)
    );

    typedef struct {
        logic [1:0]  grant;
        logic [7:0]  prot;
        logic        valid, start, last, cancel, to_err;
        logic [15:0] data;
        logic [1:0]  len;
        int          gap;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         last_ev = 0;
    logic       mon_en = 1'b0;
    logic [1:0] prev_grant = 2'b00;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void ev(logic [1:0] g, logic [7:0] p, logic v, logic s, logic l,
                               logic c, logic te, logic [15:0] d, logic [1:0] len, int gap);
        exp_t e;
        e.grant = g; e.prot = p; e.valid = v; e.start = s; e.last = l;
        e.cancel = c; e.to_err = te; e.data = d; e.len = len; e.gap = gap;
        q.push_back(e);
    endfunction

    // Monitor: an event is any cycle with traffic, cancel, timeout or a grant change.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && (valid_o || cancel_o || to_err_o || (grant_o != prev_grant))) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: grant=%b valid=%b cancel=%b to_err=%b data=%h, expected no event (cycle %0d)",
                             grant_o, valid_o, cancel_o, to_err_o, data_o, cyc);
                end else begin
                    e = q.pop_front();
                    chk("grant", 32'(grant_o), 32'(e.grant));
                    chk("prot", 32'(prot_o), 32'(e.prot));
                    chk("valid", 32'(valid_o), 32'(e.valid));
                    chk("start", 32'(start_o), 32'(e.start));
                    chk("last", 32'(last_o), 32'(e.last));
                    chk("cancel", 32'(cancel_o), 32'(e.cancel));
                    chk("to_err", 32'(to_err_o), 32'(e.to_err));
                    if (e.valid) begin
                        chk("data", 32'(data_o), 32'(e.data));
                        chk("len", 32'(len_o), 32'(e.len));
                    end
                    if (e.gap >= 0) chk("event_gap", 32'(cyc - last_ev), 32'(e.gap));
                end
                last_ev    = cyc;
                prev_grant = grant_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid_i = '0; start_i = '0; last_i = '0; cancel_i = '0; data_i = '0; len_i = '0;
    endtask

    task automatic beat(int r, logic s, logic l, logic [15:0] d, logic [1:0] len);
        valid_i[r] = 1'b1;
        start_i[r] = s;
        last_i[r]  = l;
        data_i[r*16 +: 16] = d;
        len_i[r*2 +: 2]    = len;
    endtask

    // Two-beat packet starting in the cycle the grant appears; returns in the
    // cycle where the next grant may appear.
    task automatic pkt2(int r, logic [1:0] g, logic [7:0] p, logic [15:0] d0, logic [15:0] d1,
                        logic [1:0] req_after, int gap0);
        idle_in(); beat(r, 1'b1, 1'b0, d0, 2'd2);
        ev(g, p, 1, 1, 0, 0, 0, d0, 2'd2, gap0); step();
        idle_in(); beat(r, 1'b0, 1'b1, d1, 2'd1); req_i = req_after;
        ev(g, p, 1, 0, 1, 0, 0, d1, 2'd1, 1); step();
        idle_in();
        ev(2'b00, p, 0, 0, 0, 0, 0, 16'h0, 2'd0, 1); step();
    endtask

    initial begin
        // Reset with noisy inputs: every output must be quiet.
        nreset = 1'b0; req_i = 2'b11; valid_i = 2'b11; start_i = 2'b11; last_i = 2'b11;
        cancel_i = 2'b11; data_i = 32'hFFFF_FFFF; len_i = 4'hF;
        repeat (3) step();
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_prot", 32'(prot_o), 0);
        chk("rst_to_err", 32'(to_err_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_start", 32'(start_o), 0);
        chk("rst_last", 32'(last_o), 0);
        chk("rst_cancel", 32'(cancel_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_len", 32'(len_o), 0);
        nreset = 1'b1; req_i = 2'b00; idle_in();
        mon_en = 1'b1;
        step();

        // Single requester, 3-beat packet.
        req_i = 2'b01; step();
        beat(0, 1'b1, 1'b0, 16'h4500, 2'd2);
        ev(2'b01, 8'd17, 1, 1, 0, 0, 0, 16'h4500, 2'd2, -1); step();
        idle_in(); beat(0, 1'b0, 1'b0, 16'h0030, 2'd2); req_i = 2'b00;
        ev(2'b01, 8'd17, 1, 0, 0, 0, 0, 16'h0030, 2'd2, 1); step();
        idle_in(); beat(0, 1'b0, 1'b1, 16'h0000, 2'd2);
        ev(2'b01, 8'd17, 1, 0, 1, 0, 0, 16'h0000, 2'd2, 1); step();
        idle_in();
        ev(2'b00, 8'd17, 0, 0, 0, 0, 0, 16'h0, 2'd0, 1); step();

        // Fresh reset so the round-robin pointer starts at requester 0.
        nreset = 1'b0; step();
        nreset = 1'b1; step();

        // Contention: grants alternate 01, 10, 01, 10.
        req_i = 2'b11; step();
        pkt2(0, 2'b01, 8'd17, 16'hA000, 16'hA001, 2'b11, -1);
        pkt2(1, 2'b10, 8'd1,  16'hB000, 16'hB001, 2'b11, 1);
        pkt2(0, 2'b01, 8'd17, 16'hA010, 16'hA011, 2'b11, 1);
        pkt2(1, 2'b10, 8'd1,  16'hB010, 16'hB011, 2'b00, 1);

        // Timeout: requester 1 never starts; stray valid beats must be dropped.
        req_i = 2'b10; step();
        ev(2'b10, 8'd1, 0, 0, 0, 0, 0, 16'h0, 2'd0, -1);
        for (int i = 0; i < 64; i++) begin
            idle_in();
            if (i % 3 == 1) beat(1, 1'b0, 1'b0, 16'h1234, 2'd2);
            step();
        end
        idle_in(); req_i = 2'b11;
        ev(2'b00, 8'd1, 0, 0, 0, 0, 1, 16'h0, 2'd0, 64); step();

        // Cancel mid-packet, then requester 1 granted and drops its request.
        beat(0, 1'b1, 1'b0, 16'hC000, 2'd2);
        ev(2'b01, 8'd17, 1, 1, 0, 0, 0, 16'hC000, 2'd2, 1); step();
        idle_in(); beat(0, 1'b0, 1'b0, 16'hC001, 2'd2); cancel_i[0] = 1'b1;
        ev(2'b01, 8'd17, 1, 0, 0, 1, 0, 16'hC001, 2'd2, 1); step();
        idle_in();
        ev(2'b00, 8'd17, 0, 0, 0, 0, 0, 16'h0, 2'd0, 1); step();
        ev(2'b10, 8'd1, 0, 0, 0, 0, 0, 16'h0, 2'd0, 1); req_i = 2'b01; step();
        ev(2'b00, 8'd1, 0, 0, 0, 0, 0, 16'h0, 2'd0, 1); step();

        // Interference from requester 1 while requester 0 transfers.
        idle_in(); beat(0, 1'b1, 1'b0, 16'hD000, 2'd2); beat(1, 1'b1, 1'b0, 16'hFFFF, 2'd3);
        cancel_i[1] = 1'b1;
        ev(2'b01, 8'd17, 1, 1, 0, 0, 0, 16'hD000, 2'd2, 1); step();
        idle_in(); beat(0, 1'b1, 1'b0, 16'hD001, 2'd2); beat(1, 1'b1, 1'b1, 16'hFFFF, 2'd3);
        cancel_i[1] = 1'b1;
        ev(2'b01, 8'd17, 1, 0, 0, 0, 0, 16'hD001, 2'd2, 1); step();
        idle_in(); beat(0, 1'b0, 1'b0, 16'hD002, 2'd2); beat(1, 1'b1, 1'b0, 16'hEEEE, 2'd3);
        nreset = 1'b0;
        ev(2'b01, 8'd17, 1, 0, 0, 0, 0, 16'hD002, 2'd2, 1); step();

        // Mid-packet reset: all outputs zero even with valid inputs present.
        idle_in(); valid_i = 2'b11; start_i = 2'b11; data_i = 32'h5555_6666;
        nreset = 1'b1; req_i = 2'b11;
        ev(2'b00, 8'd0, 0, 0, 0, 0, 0, 16'h0, 2'd0, 1); step();

        // Pointer back at 0: requester 0 wins; single-beat packet.
        idle_in(); beat(0, 1'b1, 1'b1, 16'hE000, 2'd1); req_i = 2'b01;
        ev(2'b01, 8'd17, 1, 1, 1, 0, 0, 16'hE000, 2'd1, 1); step();
        idle_in(); req_i = 2'b00;
        ev(2'b00, 8'd17, 0, 0, 0, 0, 0, 16'h0, 2'd0, 1); step();

        repeat (5) step();
        chk("queue_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
